// File: rtl/wrr_burst_arbiter_if.sv
// wrr_burst_arbiter_if: requester/resource bundle for the weighted round-robin arbiter
interface wrr_burst_arbiter_if #(parameter int N = 5, parameter int WW = 3);
  logic [N-1:0]         req;
  logic [N*WW-1:0]      weight;
  logic                 done;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] gnt_id;
  logic                 gnt_vld;
  logic [WW-1:0]        credit;
  modport master (output req, weight, done, input gnt, gnt_id, gnt_vld, credit);
  modport slave (input req, weight, done, output gnt, gnt_id, gnt_vld, credit);
endinterface

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter; owner holds grant for up to weight[i] transactions
module wrr_burst_arbiter #(parameter int N = 5, parameter int WW = 3) (
  input logic clk,
  input logic rst_n,
  wrr_burst_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN = 1'b1;
  logic [0:0] state;
  logic [N-1:0] gnt_r;
  logic [IW-1:0] id_r, ptr, nxt_ptr, sel_ptr, mwin, uwin, win;
  logic [WW-1:0] credit_r, win_wt, load_wt;
  logic mhit, uhit, rel;
  assign rel = state == OWN && bus.done && (credit_r == WW'(1) || !bus.req[id_r]);
  assign nxt_ptr = id_r == IW'(N - 1) ? '0 : id_r + IW'(1);
  // on release the search already starts past the outgoing owner
  assign sel_ptr = rel ? nxt_ptr : ptr;
  always_comb begin
    mwin = '0;
    uwin = '0;
    mhit = 1'b0;
    uhit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i] && IW'(i) >= sel_ptr) begin
        mwin = IW'(i);
        mhit = 1'b1;
      end
      if (bus.req[i]) begin
        uwin = IW'(i);
        uhit = 1'b1;
      end
    end
  end
  assign win = mhit ? mwin : uwin;
  assign win_wt = bus.weight[int'(win)*WW +: WW];
  assign load_wt = win_wt == '0 ? WW'(1) : win_wt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      gnt_r <= '0;
      id_r <= '0;
      credit_r <= '0;
    end else if (rel || state == IDLE) begin
      if (rel) ptr <= nxt_ptr;
      state <= uhit ? OWN : IDLE;
      gnt_r <= uhit ? N'(1) << win : '0;
      id_r <= uhit ? win : '0;
      credit_r <= uhit ? load_wt : '0;
    end else if (bus.done) begin
      credit_r <= credit_r - WW'(1);
    end
  end
  assign bus.gnt = gnt_r;
  assign bus.gnt_id = id_r;
  assign bus.gnt_vld = |gnt_r;
  assign bus.credit = credit_r;
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: directed scenarios plus randomized run against a tenure-level reference model
module tb_wrr_burst_arbiter;
  localparam int N = 5;
  localparam int WW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_owner, m_ptr, m_credit;
  logic [N-1:0] m_gnt;
  wrr_burst_arbiter_if #(.N(N), .WW(WW)) bus ();
  wrr_burst_arbiter #(.N(N), .WW(WW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic int wt(int w);
    int v;
    v = int'(bus.weight[w*WW +: WW]);
    return v == 0 ? 1 : v;
  endfunction
  task automatic model_reset();
    m_owner = -1;
    m_ptr = 0;
    m_credit = 0;
    m_gnt = '0;
  endtask
  task automatic model_edge();
    int w;
    w = -1;
    if (m_owner < 0) begin
      w = pick(bus.req, m_ptr);
      if (w >= 0) begin m_owner = w; m_credit = wt(w); end
    end else if (bus.done) begin
      if (m_credit > 1 && bus.req[m_owner]) m_credit--;
      else begin
        m_ptr = (m_owner + 1) % N;
        w = pick(bus.req, m_ptr);
        if (w >= 0) begin m_owner = w; m_credit = wt(w); end
        else begin m_owner = -1; m_credit = 0; end
      end
    end
    m_gnt = m_owner < 0 ? '0 : N'(1) << m_owner;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    bus.weight = {5{3'd1}};
    do_reset();
    checks++;
    if (bus.gnt !== 5'b0 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 3'd0 || bus.credit !== 3'd0) begin
      errors++;
      $display("FAIL reset_state gnt=%b vld=%b id=%0d credit=%0d want 00000/0/0/0", bus.gnt, bus.gnt_vld, bus.gnt_id, bus.credit);
    end
    bus.req = 5'b00001;
    #1;
    checks++;
    if (bus.gnt !== 5'b0) begin
      errors++;
      $display("FAIL no_comb_path gnt=%b want 00000", bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 5'b00001 || bus.gnt_id !== 3'd0 || bus.credit !== 3'd1 || bus.gnt_vld !== 1'b1) begin
      errors++;
      $display("FAIL first_grant gnt=%b id=%0d credit=%0d want 00001/0/1", bus.gnt, bus.gnt_id, bus.credit);
    end
  endtask
  task automatic test_handoff();
    bus.weight = {5{3'd1}};
    do_reset();
    bus.req = 5'b00110;
    step();
    checks++;
    if (bus.gnt !== 5'b00010) begin
      errors++;
      $display("FAIL handoff_first gnt=%b want 00010", bus.gnt);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 5'b00100 || bus.gnt_vld !== 1'b1 || bus.gnt_id !== 3'd2) begin
      errors++;
      $display("FAIL handoff_zero_bubble gnt=%b vld=%b id=%0d want 00100/1/2", bus.gnt, bus.gnt_vld, bus.gnt_id);
    end
  endtask
  task automatic test_wrap();
    bus.weight = {5{3'd1}};
    do_reset();
    bus.req = 5'b10000;
    step();
    checks++;
    if (bus.gnt !== 5'b10000) begin
      errors++;
      $display("FAIL wrap_owner4 gnt=%b want 10000", bus.gnt);
    end
    bus.req = 5'b00011;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 5'b00001 || bus.gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL wrap_to_0 gnt=%b id=%0d want 00001/0", bus.gnt, bus.gnt_id);
    end
  endtask
  task automatic test_weighted();
    int exp_id[8] = '{0, 1, 2, 2, 2, 3, 4, 0};
    int exp_cr[8] = '{1, 1, 3, 2, 1, 1, 1, 1};
    bus.weight = {3'd1, 3'd1, 3'd3, 3'd1, 3'd1};
    do_reset();
    bus.req = 5'b11111;
    step();
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (bus.gnt_id !== 3'(exp_id[t]) || bus.credit !== 3'(exp_cr[t]) || bus.gnt !== N'(1) << exp_id[t]) begin
        errors++;
        $display("FAIL weighted_order[%0d] id=%0d credit=%0d gnt=%b want id=%0d credit=%0d", t, bus.gnt_id, bus.credit, bus.gnt, exp_id[t], exp_cr[t]);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      step();
    end
  endtask
  task automatic test_drop();
    bus.weight = {3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
    do_reset();
    bus.req = 5'b00010;
    step();
    bus.req = 5'b00000;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (bus.gnt !== 5'b00010 || bus.credit !== 3'd2) begin
        errors++;
        $display("FAIL drop_hold[%0d] gnt=%b credit=%0d want 00010/2", t, bus.gnt, bus.credit);
      end
    end
    bus.done = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 5'b0 || bus.gnt_vld !== 1'b0 || bus.credit !== 3'd0) begin
      errors++;
      $display("FAIL drop_release gnt=%b vld=%b credit=%0d want 00000/0/0", bus.gnt, bus.gnt_vld, bus.credit);
    end
    step();
    bus.done = 1'b0;
    checks++;
    if (bus.gnt !== 5'b0 || bus.gnt_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_done gnt=%b vld=%b want 00000/0", bus.gnt, bus.gnt_vld);
    end
  endtask
  task automatic test_async_reset();
    bus.weight = {5{3'd1}};
    do_reset();
    bus.req = 5'b00010;
    step();
    bus.done = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 5'b00010 || bus.credit !== 3'd1) begin
      errors++;
      $display("FAIL sole_regain gnt=%b credit=%0d want 00010/1", bus.gnt, bus.credit);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 5'b0 || bus.gnt_vld !== 1'b0 || bus.credit !== 3'd0) begin
      errors++;
      $display("FAIL async_reset gnt=%b vld=%b credit=%0d want 00000/0/0", bus.gnt, bus.gnt_vld, bus.credit);
    end
    model_reset();
    bus.done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 5'b01001;
    step();
    checks++;
    if (bus.gnt !== 5'b00001) begin
      errors++;
      $display("FAIL ptr_cleared gnt=%b want 00001", bus.gnt);
    end
  endtask
  task automatic test_random();
    bus.weight = $urandom;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
      bus.done = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 15) == 0) bus.weight = $urandom;
      step();
      checks++;
      if (bus.gnt !== m_gnt || bus.credit !== 3'(m_credit) || bus.gnt_vld !== (m_owner >= 0) ||
          (m_owner >= 0 && bus.gnt_id !== 3'(m_owner)) || !$onehot0(bus.gnt)) begin
        errors++;
        $display("FAIL random[%0d] gnt=%b id=%0d vld=%b credit=%0d want gnt=%b id=%0d credit=%0d", c, bus.gnt, bus.gnt_id, bus.gnt_vld, bus.credit, m_gnt, m_owner, m_credit);
      end
    end
    bus.done = 1'b0;
  endtask
  initial begin
    bus.req = '0;
    bus.done = 1'b0;
    bus.weight = '0;
    model_reset();
    test_reset();
    test_handoff();
    test_wrap();
    test_weighted();
    test_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end
endmodule
